// File: rtl/dice_roller.sv
// dice_roller: a set of NUM_DICE electronic dice with FACES faces each.
//
// The dice keep advancing while 'button' is held, and every roll makes at
// least MIN_ROLL advances. When the roll settles, the block publishes the
// faces, their sum, a one-cycle 'valid' strobe and a running roll count.
//
// Ports:
//   clk        in   single clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   button     in   roll request, already synchronised
//   throw      out  packed faces, die k at [k*W +: W], each in 1..FACES
//   sum        out  registered sum of all faces
//   valid      out  one-cycle strobe while the settle state is active
//   rolling    out  high while the dice are advancing
//   roll_count out  completed rolls, wraps modulo 2^CNT_W
module dice_roller #(
  parameter int FACES    = 6,
  parameter int NUM_DICE = 2,
  parameter int MIN_ROLL = 8,
  parameter int CNT_W    = 16,
  localparam int W       = $clog2(FACES + 1),
  localparam int SW      = $clog2(NUM_DICE * FACES + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  button,
  output logic [NUM_DICE*W-1:0] throw,
  output logic [SW-1:0]         sum,
  output logic                  valid,
  output logic                  rolling,
  output logic [CNT_W-1:0]      roll_count
);

  typedef enum logic [1:0] {
    IDLE,
    ROLL,
    EXTEND,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [15:0]   adv;
  logic [15:0]   adv_next;
  logic          advance;
  logic          reach;
  logic [16:0]   adv_inc;
  logic [W-1:0]  die      [NUM_DICE];
  logic [W-1:0]  die_next [NUM_DICE];
  logic [SW-1:0] sum_next;

  // Widened by one bit so the "this advance reaches MIN_ROLL" test cannot
  // overflow when adv sits at 16'hFFFF.
  assign adv_inc = {1'b0, adv} + 17'd1;
  assign reach   = (adv_inc >= 17'(MIN_ROLL));

  // Next-state logic. Any edge spent in ROLL or EXTEND advances the dice,
  // including the edge that leaves for DONE, so the final advance lands on
  // the edge entering DONE. Returning from EXTEND to ROLL keeps adv.
  always_comb begin
    state_next = state;
    adv_next   = adv;
    advance    = 1'b0;
    case (state)
      IDLE: begin
        if (button) begin
          state_next = ROLL;
          adv_next   = '0;
        end
      end
      ROLL: begin
        advance = 1'b1;
        if (!button) begin
          state_next = reach ? DONE : EXTEND;
        end
      end
      EXTEND: begin
        advance = 1'b1;
        if (button) begin
          state_next = ROLL;
        end else if (reach) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (advance && (adv < 16'(MIN_ROLL))) begin
      adv_next = adv + 16'd1;
    end
  end

  // Odometer: die 0 steps whenever the dice advance; each higher die steps
  // only when the die below it wraps from FACES back to 1. The carry is a
  // local variable so the chain stays a simple ripple.
  always_comb begin
    logic carry;
    carry = advance;
    for (int k = 0; k < NUM_DICE; k++) begin
      die_next[k] = die[k];
      if (carry) begin
        die_next[k] = (die[k] == W'(FACES)) ? W'(1) : die[k] + W'(1);
      end
      carry = carry && (die[k] == W'(FACES));
    end
  end

  // Sum of the post-advance faces; SW is sized so this never overflows.
  always_comb begin
    sum_next = '0;
    for (int k = 0; k < NUM_DICE; k++) begin
      sum_next = sum_next + SW'(die_next[k]);
    end
  end

  // State, step counter and dice. Reset puts every die on face 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      adv   <= '0;
      for (int k = 0; k < NUM_DICE; k++) begin
        die[k] <= W'(1);
      end
    end else begin
      state <= state_next;
      adv   <= adv_next;
      for (int k = 0; k < NUM_DICE; k++) begin
        die[k] <= die_next[k];
      end
    end
  end

  // The sum is captured only on the edge entering DONE, so it matches the
  // settled faces while valid is high and holds until the next settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum <= SW'(NUM_DICE);
    end else if (state_next == DONE && state != DONE) begin
      sum <= sum_next;
    end
  end

  // A roll counts as completed on the edge leaving DONE; a reset during the
  // roll never reaches DONE and so is never counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      roll_count <= '0;
    end else if (state == DONE) begin
      roll_count <= roll_count + CNT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_DICE; g++) begin : g_throw
    assign throw[g*W +: W] = die[g];
  end

  assign rolling = (state == ROLL) || (state == EXTEND);
  assign valid   = (state == DONE);

endmodule

// File: doc/dice_roller.md
# dice_roller

Parametrised multi-die electronic dice for the board's user-I/O section. It generalises the single six-sided die to NUM_DICE dice of FACES faces each. All dice roll while `button` is held, and each roll lasts at least MIN_ROLL steps. On settle, the block publishes per-die faces, their sum, a one-cycle `valid` strobe and a running roll count.

## Interface
- FACES, 6, faces per die; legal range 2..255.
- NUM_DICE, 2, number of dice; legal range 1..8.
- MIN_ROLL, 8, minimum advances per roll; legal range 1..65535.
- CNT_W, 16, width of the roll counter.
- Derived: W = $clog2(FACES+1), SW = $clog2(NUM_DICE*FACES+1).
- clk, input, 1, single clock; all state changes on its rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- button, input, 1, roll request, already synchronised upstream; sampled on every clk edge.
- throw, output, NUM_DICE*W, packed faces; die k occupies bits [k*W +: W]; every value is in 1..FACES.
- sum, output, SW, sum of all faces, registered.
- valid, output, 1, one-cycle strobe when a roll has settled.
- rolling, output, 1, high while the dice are advancing.
- roll_count, output, CNT_W, number of completed rolls; wraps modulo 2^CNT_W.

## Operation
- FSM states:
  - IDLE: dice hold their values.
  - ROLL: button held; dice advance on every edge.
  - EXTEND: button released before MIN_ROLL was reached; dice keep advancing.
  - DONE: one-cycle settle state.
- Advance rule, applied on every edge in ROLL or EXTEND:
  - Die 0 steps 1→2→…→FACES→1.
  - Die k (k≥1) steps only on an edge where die k-1 wraps from FACES to 1, like an odometer.
  - Die NUM_DICE-1 wraps freely.
- Step counter `adv` (internal, 16 bit):
  - Cleared on IDLE→ROLL.
  - Incremented on every advance, saturating at MIN_ROLL.
- Transitions, evaluated per edge:
  - IDLE: button=1 → ROLL; otherwise stay.
  - ROLL: button=1 → stay. button=0 → DONE if adv+1 ≥ MIN_ROLL, else EXTEND.
  - EXTEND: button=1 → ROLL, and the roll continues without clearing adv. button=0 → DONE if adv+1 ≥ MIN_ROLL, else stay.
  - DONE → IDLE unconditionally. A button held through DONE starts a new roll from IDLE on the following edge.
- Output encoding:
  - rolling = (state==ROLL || state==EXTEND).
  - valid = (state==DONE).
- sum update:
  - Loaded on the edge entering DONE, from the post-advance face values.
  - Held at all other times.
  - Arithmetic is unsigned at SW bits and cannot overflow.
- roll_count increments by 1 on the edge leaving DONE.
- Consequence: if button is sampled high on k consecutive edges starting from IDLE, the roll makes exactly max(k, MIN_ROLL) advances.

## Timing
- Reset (rst_n=0, asynchronous, takes effect immediately):
  - Every die = 1.
  - sum = NUM_DICE.
  - valid = 0, rolling = 0, roll_count = 0, state = IDLE, adv = 0.
- Reset mid-roll: the in-flight roll is discarded, with no valid and no count increment. Release is synchronous: the first edge with rst_n=1 samples button normally.
- Button high sampled at edge e0: rolling=1 after e0; first advance at e1.
- Last advance occurs on the edge entering DONE; throw and sum are both final while valid=1.
- valid is high for exactly one cycle.
- rolling falls on the same edge that valid rises.
- roll_count changes one cycle after valid rises.
- Release-to-valid latency:
  - 1 cycle when the press reached MIN_ROLL.
  - Otherwise MIN_ROLL-k extra cycles.
- Outputs are registered except rolling and valid, which are decoded directly from the state register.

## Test plan
- Reset check: assert rst_n=0 asynchronously between edges; outputs go to reset values immediately. With FACES=6, NUM_DICE=2: throw={1,1}, sum=2, roll_count=0.
- Short press with defaults: button high for 3 edges, then low. Required response: 8 advances, then valid for 1 cycle with die0=3, die1=2, sum=5. rolling is high for 8 cycles; roll_count becomes 1.
- Long press from reset: button high for 20 edges. Required response: 20 advances, then valid with die0=3, die1=4, sum=7. Release-to-valid is 1 cycle.
- Re-press during EXTEND: press 2 edges, release 2 edges, press 10 edges, release. Required response: adv is not cleared. Total advances = 2 + 2 (EXTEND) + 10 = 14, giving die0=3, die1=3, sum=6, and exactly one valid.
- Reset mid-roll: apply rst_n=0 at the 5th ROLL cycle. Required response: no valid strobe, roll_count stays 0, throw returns to {1,1}. A subsequent roll behaves as it would from reset.
- Boundary configuration FACES=2, NUM_DICE=3, MIN_ROLL=1: 1-edge press → die0=2, sum=4. Seven 1-edge rolls then accumulate to {2,2,2}, sum=6; the eighth wraps to {1,1,1}, sum=3. roll_count counts 8, and no face is ever 0 or >FACES.
